// File: rtl/sap1_memory.sv
// SAP-1 memory unit: 4-bit MAR, 16x8 RAM on the W-bus, and a byte-stream loader port.
// Optional SAP1_MEM_ZERO_FILL_EN: a partial load zero-fills the remaining words before RUN.
module sap1_memory #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              mar_loadn_i,
  input  logic              ram_enn_i,
  input  logic [DATA_W-1:0] bus_i,
  output logic [DATA_W-1:0] bus_o,
  output logic              bus_oe_o,
  input  logic              prog_mode_i,
  input  logic              prog_valid_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic              prog_ready_o,
  output logic              prog_done_o,
  output logic              run_rstn_o
);

  // state | meaning
  // RUN   | CPU running; MAR/RAM answer the control word
  // PROG  | CPU held in reset; loader bytes accepted into mem[wptr]
  // FULL  | all DEPTH words written; waiting for mode to drop
  // FILL  | (macro only) zeroing mem[wptr..DEPTH-1] after a partial load
`ifdef SAP1_MEM_ZERO_FILL_EN
  typedef enum logic [1:0] {RUN = 2'd0, PROG = 2'd1, FULL = 2'd2, FILL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, PROG = 2'd1, FULL = 2'd2} state_t;
`endif

  localparam logic [ADDR_W:0] LAST_P  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   mar, mar_d;
  logic [ADDR_W:0]     wptr, wptr_d;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                unused_bus;

  assign unused_bus = ^bus_i[DATA_W-1:ADDR_W];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= RUN;
      mar   <= '0;
      wptr  <= '0;
    end else begin
      state <= state_d;
      mar   <= mar_d;
      wptr  <= wptr_d;
    end
  end

  always_comb begin
    state_d = state;
    mar_d   = mar;
    wptr_d  = wptr;
    we      = 1'b0;
    waddr   = wptr[ADDR_W-1:0];
    wdata   = prog_data_i;
    case (state)
      RUN: begin
        if (!mar_loadn_i) mar_d = bus_i[ADDR_W-1:0];
        if (prog_mode_i) begin
          state_d = PROG;
          wptr_d  = '0;
        end
      end
      PROG: begin
        if (prog_valid_i) begin
          we     = 1'b1;
          wptr_d = wptr + 1'b1;
        end
        if (!prog_mode_i) begin
          // a byte handshaked on the exit cycle still counts toward wptr
          mar_d = '0;
`ifdef SAP1_MEM_ZERO_FILL_EN
          state_d = (wptr_d < DEPTH_P) ? FILL : RUN;
`else
          state_d = RUN;
`endif
        end else if (prog_valid_i && wptr == LAST_P) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (!prog_mode_i) begin
          mar_d   = '0;
          state_d = RUN;
        end
      end
`ifdef SAP1_MEM_ZERO_FILL_EN
      FILL: begin
        we     = 1'b1;
        wdata  = '0;
        wptr_d = wptr + 1'b1;
        if (wptr == LAST_P) state_d = RUN;
      end
`endif
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign prog_ready_o = (state == PROG);
  assign prog_done_o  = (state == FULL);
  assign run_rstn_o   = (state == RUN);
  assign bus_oe_o     = (state == RUN) && !ram_enn_i;
  assign bus_o        = bus_oe_o ? mem[mar] : '0;

endmodule

// File: tb/tb_sap1_memory.sv
// Self-checking bench for sap1_memory: directed cases plus randomized loads against an array model.
module tb_sap1_memory;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       mar_loadn_i, ram_enn_i;
  logic [7:0] bus_i, bus_o;
  logic       bus_oe_o;
  logic       prog_mode_i, prog_valid_i;
  logic [7:0] prog_data_i;
  logic       prog_ready_o, prog_done_o, run_rstn_o;

  sap1_memory dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .mar_loadn_i(mar_loadn_i), .ram_enn_i(ram_enn_i),
    .bus_i(bus_i), .bus_o(bus_o), .bus_oe_o(bus_oe_o),
    .prog_mode_i(prog_mode_i), .prog_valid_i(prog_valid_i), .prog_data_i(prog_data_i),
    .prog_ready_o(prog_ready_o), .prog_done_o(prog_done_o), .run_rstn_o(run_rstn_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [16];
  bit zero_fill;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic read_check(input int addr, input string tag);
    bus_i = 8'(addr);
    mar_loadn_i = 1'b0;
    step();
    mar_loadn_i = 1'b1;
    ram_enn_i = 1'b0;
    #1;
    chk({tag, "_data"}, bus_o, ref_mem[addr]);
    chk({tag, "_oe"}, bus_oe_o, 1'b1);
    step();
    ram_enn_i = 1'b1;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) read_check(a, tag);
  endtask

  task automatic wait_run(input string tag, output int cyc);
    cyc = 0;
    while (!run_rstn_o && cyc < 40) begin
      step();
      cyc++;
    end
    chk({tag, "_exit_timeout"}, run_rstn_o, 1'b1);
  endtask

  // model of the post-exit fill rule applied to a load of n bytes
  task automatic model_exit(input int n);
    if (zero_fill)
      for (int a = n; a < 16; a++) ref_mem[a] = 8'h00;
  endtask

  initial begin
    int cyc;
    int n;
    bit early;
    logic [7:0] d;
`ifdef SAP1_MEM_ZERO_FILL_EN
    zero_fill = 1'b1;
`else
    zero_fill = 1'b0;
`endif
    rstn_i = 1'b0; mar_loadn_i = 1'b1; ram_enn_i = 1'b1; bus_i = 8'h00;
    prog_mode_i = 1'b0; prog_valid_i = 1'b0; prog_data_i = 8'h00;
    #1;
    chk("rst_ready", prog_ready_o, 1'b0);
    chk("rst_done", prog_done_o, 1'b0);
    chk("rst_run_rstn", run_rstn_o, 1'b1);
    chk("rst_oe", bus_oe_o, 1'b0);
    chk("rst_bus", bus_o, 8'h00);
    step(); step();
    rstn_i = 1'b1;
    step();

    // full load 0x10..0x1F
    prog_mode_i = 1'b1;
    step();
    chk("prog_run_rstn", run_rstn_o, 1'b0);
    chk("prog_ready", prog_ready_o, 1'b1);
    ram_enn_i = 1'b0;
    #1;
    chk("prog_oe_blocked", bus_oe_o, 1'b0);
    ram_enn_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_valid_i = 1'b1;
      prog_data_i = 8'h10 + 8'(i);
      if (i < 15) chk("full_done_early", prog_done_o, 1'b0);
      step();
      ref_mem[i] = 8'h10 + 8'(i);
    end
    chk("full_done", prog_done_o, 1'b1);
    chk("full_ready", prog_ready_o, 1'b0);
    prog_data_i = 8'hEE;
    step();
    chk("byte17_ready", prog_ready_o, 1'b0);
    chk("byte17_done", prog_done_o, 1'b1);
    prog_valid_i = 1'b0;
    prog_mode_i = 1'b0;
    step();
    chk("full_exit_run_rstn", run_rstn_o, 1'b1);
    chk("full_exit_done", prog_done_o, 1'b0);
    read_check(5, "read5");
    read_all("after_full");

    // partial load of 3 bytes
    prog_mode_i = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      d = 8'hAA + 8'(i * 17);
      prog_valid_i = 1'b1;
      prog_data_i = d;
      step();
      ref_mem[i] = d;
    end
    prog_valid_i = 1'b0;
    prog_mode_i = 1'b0;
    step();
    cyc = 1;
    while (!run_rstn_o && cyc < 40) begin
      step();
      cyc++;
    end
    chk("partial_exit_cycles", 32'(cyc), zero_fill ? 32'd14 : 32'd1);
    model_exit(3);
    read_all("after_partial");

    // loader input ignored in RUN
    prog_valid_i = 1'b1;
    prog_data_i = 8'h77;
    for (int i = 0; i < 4; i++) begin
      chk("run_ready", prog_ready_o, 1'b0);
      step();
    end
    prog_valid_i = 1'b0;
    read_all("run_ignore");

    // async reset after 5 bytes
    bus_i = 8'h0B; mar_loadn_i = 1'b0;
    step();
    mar_loadn_i = 1'b1;
    prog_mode_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h40 + i * 3);
      prog_valid_i = 1'b1;
      prog_data_i = d;
      step();
      ref_mem[i] = d;
    end
    prog_valid_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_run_rstn", run_rstn_o, 1'b1);
    chk("arst_ready", prog_ready_o, 1'b0);
    prog_mode_i = 1'b0;
    step();
    rstn_i = 1'b1;
    step();
    ram_enn_i = 1'b0;
    #1;
    chk("arst_mar0", bus_o, ref_mem[0]);
    ram_enn_i = 1'b1;
    for (int a = 0; a < 5; a++) read_check(a, "arst_kept");

    // MAR ignored in PROG and cleared on exit
    bus_i = 8'h07; mar_loadn_i = 1'b0;
    step();
    mar_loadn_i = 1'b1;
    prog_mode_i = 1'b1;
    step();
    bus_i = 8'h09; mar_loadn_i = 1'b0;
    step();
    mar_loadn_i = 1'b1;
    prog_mode_i = 1'b0;
    step();
    wait_run("mar_prog", cyc);
    model_exit(0);
    ram_enn_i = 1'b0;
    #1;
    chk("mar_cleared", bus_o, ref_mem[0]);
    ram_enn_i = 1'b1;
    step();

    // randomized loads with gaps and occasional same-cycle exit
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 16);
      prog_mode_i = 1'b1;
      step();
      chk("rnd_ready", prog_ready_o, 1'b1);
      early = 1'b0;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          prog_valid_i = 1'b0;
          step();
        end
        d = 8'($urandom);
        prog_valid_i = 1'b1;
        prog_data_i = d;
        if (k == n - 1 && n < 16 && $urandom_range(0, 1) == 1) begin
          prog_mode_i = 1'b0;
          early = 1'b1;
        end
        step();
        ref_mem[k] = d;
      end
      prog_valid_i = 1'b0;
      if (!early) begin
        chk("rnd_done", prog_done_o, (n == 16) ? 1'b1 : 1'b0);
        prog_mode_i = 1'b0;
        step();
      end
      wait_run("rnd", cyc);
      model_exit(n);
      read_all("rnd_read");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sap1_memory.md
# sap1_memory

SAP-1 memory unit: 4-bit memory address register (MAR) plus 16x8 RAM. It answers the controller's active-low `MAR_LOAD`/`RAM_EN` control-word bits on the W-bus. It also provides a byte-stream programming port that loads the RAM while holding the CPU in reset. It sits between the controller/bus and an external loader (UART bridge or testbench), replacing the manual address/data switches of the original machine.

## Interface
- `ADDR_W`, 4, address width; MAR width
- `DATA_W`, 8, RAM word and bus width
- `DEPTH`, 16, RAM words; always 2**ADDR_W
- `clk_i`  in  1  clock; all registers on rising edge
- `rstn_i`  in  1  reset, asynchronous, active-low
- `mar_loadn_i`  in  1  control word `MAR_LOAD`, active-low
- `ram_enn_i`  in  1  control word `RAM_EN`, active-low
- `bus_i`  in  DATA_W  W-bus value; MAR takes `bus_i[ADDR_W-1:0]`
- `bus_o`  out  DATA_W  RAM read data to W-bus
- `bus_oe_o`  out  1  high while this block drives the bus
- `prog_mode_i`  in  1  level; high requests programming mode
- `prog_valid_i`  in  1  programming byte valid
- `prog_data_i`  in  DATA_W  programming byte
- `prog_ready_o`  out  1  block accepts `prog_data_i` this cycle
- `prog_done_o`  out  1  all DEPTH locations written
- `run_rstn_o`  out  1  active-low hold-reset to the rest of the CPU

## Operation
- States: RUN, PROG, FULL, FILL (FILL exists only with the macro).
- Reset values: state=RUN, MAR=0, wptr=0, `prog_ready_o`=0, `prog_done_o`=0, `run_rstn_o`=1, `bus_oe_o`=0, `bus_o`=0. RAM contents are not reset.
- RUN:
  - `mar_loadn_i`=0 → MAR <= `bus_i[3:0]` at the clock edge.
  - `ram_enn_i`=0 → `bus_oe_o`=1 and `bus_o`=mem[MAR].
  - Otherwise `bus_o`=0.
  - `prog_mode_i`=1 → PROG, with wptr <= 0.
  - `prog_valid_i` is ignored in RUN.
- PROG:
  - `run_rstn_o`=0, `prog_ready_o`=1, `bus_oe_o`=0. `mar_loadn_i` and `ram_enn_i` are ignored.
  - Handshake `prog_valid_i & prog_ready_o` → mem[wptr] <= `prog_data_i`, wptr++.
  - The write into the last location (wptr==DEPTH-1) → FULL.
  - `prog_mode_i`=0 → exit. A byte handshaked in that same cycle is still written.
- FULL:
  - `prog_ready_o`=0, `prog_done_o`=1, `run_rstn_o`=0.
  - `prog_mode_i`=0 → exit.
- Exit (from PROG or FULL): MAR <= 0. Next state is RUN, or FILL when the macro is enabled and wptr<DEPTH.
- wptr is ADDR_W+1 bits wide, so DEPTH is representable. wptr never wraps; bytes offered in FULL are not accepted.
- An asynchronous reset mid-programming returns to RUN immediately. Locations already written keep their data.

## Timing
- MAR load: value visible to RAM reads one cycle after the edge on which `mar_loadn_i`=0 is sampled.
- RAM read is combinational from MAR and `ram_enn_i` (zero-cycle), so the controller can read in the state after a MAR load.
- RUN→PROG: `run_rstn_o` falls and `prog_ready_o` rises 1 cycle after `prog_mode_i` is sampled high.
- Throughput: 1 byte/cycle; a full program takes 16 cycles.
- PROG/FULL→RUN: `run_rstn_o` rises 1 cycle after `prog_mode_i` is sampled low (no macro).
- `prog_done_o` rises on the cycle after the 16th accepted byte.

## Configuration
- `SAP1_MEM_ZERO_FILL_EN` defined:
  - A partial load exits through FILL, which writes 0 to mem[wptr..DEPTH-1], one word per cycle.
  - In FILL, `run_rstn_o`=0 and `prog_ready_o`=0. FILL then goes to RUN.
  - Exit latency is 1+(DEPTH-wptr) cycles.
- Undefined: FILL does not exist. Unwritten locations keep their previous contents and the exit takes 1 cycle.

## Test plan
- Reset, then `prog_mode_i`=1 and 16 bytes 0x10..0x1F back-to-back → `prog_done_o`=1 after the 16th byte; 17th byte not accepted (`prog_ready_o`=0).
- After full load, drop mode, then `bus_i`=0x05 with `mar_loadn_i`=0, then `ram_enn_i`=0 → `bus_o`=0x15, `bus_oe_o`=1; `run_rstn_o`=1.
- Load 3 bytes 0xAA,0xBB,0xCC then drop mode → with macro, mem[3..15]=0 after 14 cycles in total; without macro, mem[3] keeps its prior value and RUN is reached in 1 cycle.
- In RUN, `prog_valid_i`=1 with 0x77 → no write; mem unchanged, `prog_ready_o`=0.
- Assert `rstn_i`=0 after 5 bytes programmed → state RUN, MAR=0, `run_rstn_o`=1; mem[0..4] hold the written bytes.
- In PROG, `mar_loadn_i`=0 with `bus_i`=0x09 → MAR stays unchanged and reads 0 on exit.
